// File: rtl/if_stage.sv
// Instruction fetch stage: drives the instruction memory request and fills the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7,
  output logic [11:0] id_funct12,
  output logic        id_excep,
  output logic [3:0]  id_excep_code
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CODE_W    = 4;
  localparam logic [XLEN-1:0] NOP   = 32'h0000_0013;
  localparam logic [XLEN-1:0] STEP  = 32'd4;
  localparam logic [XLEN-1:0] ALIGN = 32'hFFFF_FFFC;
  localparam logic [CODE_W-1:0] EXC_MISALIGNED = 4'd0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_SKID,
    S_DROP,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   drop_addr_q, drop_addr_d;
  logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
  logic              id_valid_q, id_valid_d;
  logic [XLEN-1:0]   id_instr_q, id_instr_d;
  logic [XLEN-1:0]   id_pc_q, id_pc_d;
  logic              id_excep_q, id_excep_d;
  logic [CODE_W-1:0] id_excep_code_q, id_excep_code_d;

  logic              flush;
  logic [XLEN-1:0]   flush_pc;
  logic              misaligned;
  logic              req;
  logic [XLEN-1:0]   fetch_addr;

  // Trap outranks redirect when both arrive together.
  assign flush      = trap | redirect;
  assign flush_pc   = trap ? trap_pc : redirect_pc;
  assign misaligned = (pc_q[1:0] != 2'b00);

  // A dropped fetch keeps presenting its original address until memory answers.
  assign fetch_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;

  // Request strobe: only FETCH may start a fetch; WAIT/DROP hold the outstanding one.
  always_comb begin
    req = 1'b0;
    case (state_q)
      S_FETCH:        req = !stall && !flush && !misaligned;
      S_WAIT, S_DROP: req = 1'b1;
      default:        req = 1'b0;
    endcase
    if (!rst_n) begin
      req = 1'b0;
    end
  end

  assign imem_req  = req;
  assign imem_addr = rst_n ? (fetch_addr & ALIGN) : RESET_PC;

  // Next-state and IF/ID update logic.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    drop_addr_d     = drop_addr_q;
    skid_instr_d    = skid_instr_q;
    id_valid_d      = id_valid_q;
    id_instr_d      = id_instr_q;
    id_pc_d         = id_pc_q;
    id_excep_d      = id_excep_q;
    id_excep_code_d = id_excep_code_q;

    if (flush) begin
      // Squash IF/ID and any buffered word, retarget the fetch pc.
      id_valid_d = 1'b0;
      id_excep_d = 1'b0;
      pc_d       = flush_pc;
      if ((state_q == S_WAIT || state_q == S_DROP) && !imem_ready) begin
        state_d = S_DROP;
        if (state_q == S_WAIT) begin
          drop_addr_d = pc_q;
        end
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!stall) begin
            if (misaligned) begin
              id_valid_d      = 1'b1;
              id_instr_d      = NOP;
              id_pc_d         = pc_q;
              id_excep_d      = 1'b1;
              id_excep_code_d = EXC_MISALIGNED;
              state_d         = S_HALT;
            end else if (imem_ready) begin
              id_valid_d      = 1'b1;
              id_instr_d      = imem_rdata;
              id_pc_d         = pc_q;
              id_excep_d      = 1'b0;
              id_excep_code_d = EXC_MISALIGNED;
              pc_d            = pc_q + STEP;
            end else begin
              id_valid_d = 1'b0;
              state_d    = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_ready) begin
            pc_d = pc_q + STEP;
            if (stall) begin
              skid_instr_d = imem_rdata;
              state_d      = S_SKID;
            end else begin
              id_valid_d      = 1'b1;
              id_instr_d      = imem_rdata;
              id_pc_d         = pc_q;
              id_excep_d      = 1'b0;
              id_excep_code_d = EXC_MISALIGNED;
              state_d         = S_FETCH;
            end
          end else if (!stall) begin
            id_valid_d = 1'b0;
          end
        end
        S_SKID: begin
          // pc already advanced when the word was buffered.
          if (!stall) begin
            id_valid_d      = 1'b1;
            id_instr_d      = skid_instr_q;
            id_pc_d         = pc_q - STEP;
            id_excep_d      = 1'b0;
            id_excep_code_d = EXC_MISALIGNED;
            state_d         = S_FETCH;
          end
        end
        S_DROP: begin
          if (!stall) begin
            id_valid_d = 1'b0;
          end
          if (imem_ready) begin
            state_d = S_FETCH;
          end
        end
        S_HALT: begin
          if (!stall) begin
            id_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_FETCH;
      pc_q            <= RESET_PC;
      drop_addr_q     <= '0;
      skid_instr_q    <= '0;
      id_valid_q      <= 1'b0;
      id_instr_q      <= NOP;
      id_pc_q         <= '0;
      id_excep_q      <= 1'b0;
      id_excep_code_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      drop_addr_q     <= drop_addr_d;
      skid_instr_q    <= skid_instr_d;
      id_valid_q      <= id_valid_d;
      id_instr_q      <= id_instr_d;
      id_pc_q         <= id_pc_d;
      id_excep_q      <= id_excep_d;
      id_excep_code_q <= id_excep_code_d;
    end
  end

  assign id_valid      = id_valid_q;
  assign id_instr      = id_instr_q;
  assign id_pc         = id_pc_q;
  assign id_excep      = id_excep_q;
  assign id_excep_code = id_excep_code_q;

  // Decode fields are plain slices of the registered instruction.
  assign id_opcode  = id_instr_q[6:0];
  assign id_funct3  = id_instr_q[14:12];
  assign id_funct7  = id_instr_q[31:25];
  assign id_funct12 = id_instr_q[31:20];

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap;
  logic [31:0] trap_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [11:0] id_funct12;
  logic        id_excep;
  logic [3:0]  id_excep_code;

  int tests = 0;
  int fails = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .trap          (trap),
    .trap_pc       (trap_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_opcode     (id_opcode),
    .id_funct3     (id_funct3),
    .id_funct7     (id_funct7),
    .id_funct12    (id_funct12),
    .id_excep      (id_excep),
    .id_excep_code (id_excep_code)
  );

  always #5 clk = ~clk;

  // Instruction word the bench's memory returns for a given address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'hABC0_5033 ^ (a << 7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic rdy, input logic [31:0] data);
    imem_ready = rdy;
    imem_rdata = data;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    trap = 1'b0; trap_pc = '0; imem_ready = 1'b0; imem_rdata = '0;

    // Reset state
    tick(); tick();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", id_valid, 0);
    chk("rst_instr", id_instr, 32'h13);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_excep", id_excep, 0);
    chk("rst_code", id_excep_code, 0);

    // Zero-wait fetches of 0 and 4
    rst_n = 1'b1;
    mem(1, instr_of(32'h0)); #1;
    chk("zw_req0", imem_req, 1);
    chk("zw_addr0", imem_addr, 32'h0);
    tick();
    chk("zw_valid0", id_valid, 1);
    chk("zw_pc0", id_pc, 32'h0);
    chk("zw_instr0", id_instr, instr_of(32'h0));
    chk("zw_excep0", id_excep, 0);
    mem(1, instr_of(32'h4)); #1;
    chk("zw_addr4", imem_addr, 32'h4);
    tick();
    chk("zw_pc4", id_pc, 32'h4);
    chk("zw_valid4", id_valid, 1);

    // Address 8 answered after 3 wait cycles
    for (int i = 0; i < 3; i++) begin
      mem(0, 32'hDEAD_BEEF); #1;
      chk("ws_addr8", imem_addr, 32'h8);
      chk("ws_req8", imem_req, 1);
      tick();
      chk("ws_gap_valid", id_valid, 0);
    end
    mem(1, instr_of(32'h8)); #1;
    chk("ws_addr8_last", imem_addr, 32'h8);
    tick();
    chk("ws_valid8", id_valid, 1);
    chk("ws_pc8", id_pc, 32'h8);
    chk("ws_instr8", id_instr, instr_of(32'h8));
    chk("ws_opcode", id_opcode, 32'h33);
    chk("ws_funct3", id_funct3, 32'h5);
    chk("ws_funct7", id_funct7, 32'h55);
    chk("ws_funct12", id_funct12, 32'hABC);

    // Response for 12 arrives under stall and is skid-buffered
    mem(0, 32'h0); #1;
    chk("sk_addr12", imem_addr, 32'hC);
    tick();
    stall = 1'b1; mem(1, instr_of(32'hC)); #1;
    chk("sk_req_resp", imem_req, 1);
    tick();
    chk("sk_pc_hold1", id_pc, 32'h8);
    mem(0, 32'h0); #1;
    chk("sk_req_stalled", imem_req, 0);
    tick();
    chk("sk_pc_hold2", id_pc, 32'h8);
    stall = 1'b0; #1;
    chk("sk_req_release", imem_req, 0);
    tick();
    chk("sk_valid12", id_valid, 1);
    chk("sk_pc12", id_pc, 32'hC);
    chk("sk_instr12", id_instr, instr_of(32'hC));

    // Redirect to 0x100 while fetch of 16 waits
    mem(0, 32'h0); #1;
    chk("rd_addr16", imem_addr, 32'h10);
    tick();
    redirect = 1'b1; redirect_pc = 32'h100; #1;
    tick();
    chk("rd_flush_valid", id_valid, 0);
    redirect = 1'b0; #1;
    chk("rd_hold_addr", imem_addr, 32'h10);
    chk("rd_hold_req", imem_req, 1);
    tick();
    mem(1, instr_of(32'h10)); #1;
    tick();
    chk("rd_drop_valid", id_valid, 0);
    mem(1, instr_of(32'h100)); #1;
    chk("rd_addr100", imem_addr, 32'h100);
    tick();
    chk("rd_pc100", id_pc, 32'h100);
    chk("rd_instr100", id_instr, instr_of(32'h100));

    // Trap and redirect together: trap wins
    trap = 1'b1; trap_pc = 32'h200; redirect = 1'b1; redirect_pc = 32'h300; mem(0, 32'h0);
    tick();
    chk("tp_flush_valid", id_valid, 0);
    trap = 1'b0; redirect = 1'b0; mem(1, instr_of(32'h200)); #1;
    chk("tp_addr200", imem_addr, 32'h200);
    tick();
    chk("tp_pc200", id_pc, 32'h200);

    // Misaligned redirect target
    redirect = 1'b1; redirect_pc = 32'h102; mem(0, 32'h0);
    tick();
    chk("ma_flush_valid", id_valid, 0);
    redirect = 1'b0; #1;
    chk("ma_req", imem_req, 0);
    tick();
    chk("ma_valid", id_valid, 1);
    chk("ma_excep", id_excep, 1);
    chk("ma_code", id_excep_code, 0);
    chk("ma_pc", id_pc, 32'h102);
    chk("ma_instr", id_instr, 32'h13);
    mem(1, 32'hFFFF_FFFF); #1;
    chk("ma_halt_req", imem_req, 0);
    tick();
    chk("ma_halt_valid", id_valid, 0);
    trap = 1'b1; trap_pc = 32'h200; mem(0, 32'h0);
    tick();
    trap = 1'b0; mem(1, instr_of(32'h200)); #1;
    chk("ma_resume_req", imem_req, 1);
    chk("ma_resume_addr", imem_addr, 32'h200);
    tick();
    chk("ma_resume_pc", id_pc, 32'h200);
    chk("ma_resume_excep", id_excep, 0);

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; mem(0, 32'h0);
    tick();
    redirect = 1'b0; mem(1, instr_of(32'hFFFF_FFFC)); #1;
    chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc_top", id_pc, 32'hFFFF_FFFC);
    chk("wr_excep", id_excep, 0);
    mem(0, 32'h0); #1;
    chk("wr_addr0", imem_addr, 32'h0);
    tick();

    // Two redirects while a fetch is outstanding: the last one wins
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_pc = 32'h80; #1;
    chk("dd_hold_addr", imem_addr, 32'h0);
    tick();
    redirect = 1'b0; mem(1, 32'hBAD0_BAD0);
    tick();
    chk("dd_drop_valid", id_valid, 0);
    mem(1, instr_of(32'h80)); #1;
    chk("dd_addr80", imem_addr, 32'h80);
    tick();
    chk("dd_pc80", id_pc, 32'h80);

    // Reset in the middle of an outstanding request
    mem(0, 32'h0);
    tick();
    rst_n = 1'b0; #1;
    chk("mr_req", imem_req, 0);
    chk("mr_addr", imem_addr, 32'h0);
    tick();
    chk("mr_valid", id_valid, 0);
    chk("mr_pc", id_pc, 32'h0);
    rst_n = 1'b1; stall = 1'b1; mem(1, 32'hBAD1_BAD1); #1;
    chk("mr_stray_req", imem_req, 0);
    tick();
    chk("mr_stray_valid", id_valid, 0);
    stall = 1'b0; mem(1, instr_of(32'h0)); #1;
    chk("mr_addr0", imem_addr, 32'h0);
    tick();
    chk("mr_valid0", id_valid, 1);
    chk("mr_instr0", id_instr, instr_of(32'h0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
